// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, memory/control op encodings and the
// field values that make up a pipeline bubble.
package cpu_pkg;

  // Exception codes carried down the pipeline alongside each packet.
  typedef enum logic [2:0] {
    NO_EXP     = 3'd0,
    EXT_INT    = 3'd1,
    UNDEF_INSN = 3'd2,
    OVERFLOW   = 3'd3,
    MISS_ALIGN = 3'd4,
    TRAP       = 3'd5,
    PRV_VIO    = 3'd6
  } exp_code_e;

  // Memory-access operation requested of the MEM stage.
  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  // Control-register operation.
  typedef enum logic [1:0] {
    CTRL_OP_NONE  = 2'd0,
    CTRL_OP_WRCR  = 2'd1,
    CTRL_OP_EXRT  = 2'd2
  } ctrl_op_e;

  // Bubble values for the single-bit and small fields; wide fields bubble to 0.
  localparam logic      BUBBLE_EN      = 1'b0;
  localparam logic      BUBBLE_BR_FLAG = 1'b0;
  localparam logic      BUBBLE_GPR_WE_ = 1'b1;  // GPR write enable is active-low
  localparam logic [4:0] BUBBLE_DST    = 5'd0;

endpackage

// File: rtl/ex_reg.sv
// Execute-stage pipeline register (EX/MEM boundary).
// Captures the ALU result/overflow flag with the decode control fields, turns a
// signed overflow on a valid packet into an OVERFLOW exception, and presents a
// registered packet to MEM. Handles stall, flush and interrupt insertion.
//
// Ports:
//   clk, reset           - clock; synchronous active-low reset
//   alu_out, alu_of      - ALU result and signed-overflow flag
//   id_*                 - decode-stage packet fields
//   stall, flush         - hold the register / insert a bubble
//   int_detect           - external interrupt accepted this cycle
//   ex_*, ex_out         - registered packet to the MEM stage
module ex_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_of,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              id_en,
  input  logic              id_br_flag,
  input  logic [1:0]        id_mem_op,
  input  logic [DATA_W-1:0] id_mem_wr_data,
  input  logic [1:0]        id_ctrl_op,
  input  logic [4:0]        id_dst_addr,
  input  logic              id_gpr_we_,
  input  logic [2:0]        id_exp_code,
  input  logic              stall,
  input  logic              flush,
  input  logic              int_detect,
  output logic [ADDR_W-1:0] ex_pc,
  output logic              ex_en,
  output logic              ex_br_flag,
  output logic [1:0]        ex_mem_op,
  output logic [DATA_W-1:0] ex_mem_wr_data,
  output logic [1:0]        ex_ctrl_op,
  output logic [4:0]        ex_dst_addr,
  output logic              ex_gpr_we_,
  output logic [2:0]        ex_exp_code,
  output logic [DATA_W-1:0] ex_out
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              en_q, en_d;
  logic              br_flag_q, br_flag_d;
  logic [1:0]        mem_op_q, mem_op_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [1:0]        ctrl_op_q, ctrl_op_d;
  logic [4:0]        dst_addr_q, dst_addr_d;
  logic              gpr_we_q, gpr_we_d;
  logic [2:0]        exp_code_q, exp_code_d;
  logic [DATA_W-1:0] out_q, out_d;

  always_comb begin
    // Default: hold (covers stall).
    pc_d          = pc_q;
    en_d          = en_q;
    br_flag_d     = br_flag_q;
    mem_op_d      = mem_op_q;
    mem_wr_data_d = mem_wr_data_q;
    ctrl_op_d     = ctrl_op_q;
    dst_addr_d    = dst_addr_q;
    gpr_we_d      = gpr_we_q;
    exp_code_d    = exp_code_q;
    out_d         = out_q;

    if (!stall) begin
      // Start from a bubble; each case below loads only what it keeps.
      pc_d          = '0;
      en_d          = BUBBLE_EN;
      br_flag_d     = BUBBLE_BR_FLAG;
      mem_op_d      = MEM_OP_NONE;
      mem_wr_data_d = '0;
      ctrl_op_d     = CTRL_OP_NONE;
      dst_addr_d    = BUBBLE_DST;
      gpr_we_d      = BUBBLE_GPR_WE_;
      exp_code_d    = NO_EXP;
      out_d         = '0;

      if (flush) begin
        // Bubble; a coincident interrupt is dropped and re-raised by the controller.
      end else if (int_detect) begin
        pc_d       = id_pc;
        en_d       = id_en;
        exp_code_d = EXT_INT;
      end else if ((id_exp_code != NO_EXP) || (alu_of && id_en)) begin
        // Faulting packet: keep identity and result, suppress every side effect.
        pc_d       = id_pc;
        en_d       = id_en;
        dst_addr_d = id_dst_addr;
        out_d      = alu_out;
        // Upstream exception outranks an overflow raised here.
        exp_code_d = (id_exp_code != NO_EXP) ? id_exp_code : OVERFLOW;
      end else begin
        pc_d          = id_pc;
        en_d          = id_en;
        br_flag_d     = id_br_flag;
        mem_op_d      = id_mem_op;
        mem_wr_data_d = id_mem_wr_data;
        ctrl_op_d     = id_ctrl_op;
        dst_addr_d    = id_dst_addr;
        gpr_we_d      = id_gpr_we_;
        exp_code_d    = id_exp_code;
        out_d         = alu_out;
      end
    end
  end

  // Reset outranks stall, so a reset mid-stall still loads the bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= '0;
      en_q          <= BUBBLE_EN;
      br_flag_q     <= BUBBLE_BR_FLAG;
      mem_op_q      <= MEM_OP_NONE;
      mem_wr_data_q <= '0;
      ctrl_op_q     <= CTRL_OP_NONE;
      dst_addr_q    <= BUBBLE_DST;
      gpr_we_q      <= BUBBLE_GPR_WE_;
      exp_code_q    <= NO_EXP;
      out_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      en_q          <= en_d;
      br_flag_q     <= br_flag_d;
      mem_op_q      <= mem_op_d;
      mem_wr_data_q <= mem_wr_data_d;
      ctrl_op_q     <= ctrl_op_d;
      dst_addr_q    <= dst_addr_d;
      gpr_we_q      <= gpr_we_d;
      exp_code_q    <= exp_code_d;
      out_q         <= out_d;
    end
  end

  assign ex_pc          = pc_q;
  assign ex_en          = en_q;
  assign ex_br_flag     = br_flag_q;
  assign ex_mem_op      = mem_op_q;
  assign ex_mem_wr_data = mem_wr_data_q;
  assign ex_ctrl_op     = ctrl_op_q;
  assign ex_dst_addr    = dst_addr_q;
  assign ex_gpr_we_     = gpr_we_q;
  assign ex_exp_code    = exp_code_q;
  assign ex_out         = out_q;

endmodule
